// File: rtl/reloj_base_tiempo_pkg.sv
// Shared types and constants for the clock timekeeping core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reloj_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_AHOUR = 3'd3,
        SET_AMIN  = 3'd4
    } state_e;

    localparam int MAX_SEC  = 59;
    localparam int MAX_MIN  = 59;
    localparam int MAX_HOUR = 23;

    localparam int W_SEC  = 6;
    localparam int W_MIN  = 6;
    localparam int W_HOUR = 5;
    localparam int W_RING = 6;

    // MODE button walks the set-mode ring in a fixed order
    function automatic state_e next_state(input state_e s);
        case (s)
            RUN:       return SET_HOUR;
            SET_HOUR:  return SET_MIN;
            SET_MIN:   return SET_AHOUR;
            SET_AHOUR: return SET_AMIN;
            default:   return RUN;
        endcase
    endfunction

endpackage

// File: rtl/reloj_base_tiempo_if.sv
// Button inputs and display/buzzer outputs of the timekeeping core.
// Latency: n/a (wiring only).
// Backpressure: none; buttons are levels, outputs are always valid.
interface reloj_base_tiempo_if;
    import reloj_pkg::*;

    logic              BTN_MODE;
    logic              BTN_INC;
    logic [W_SEC-1:0]  SEC;
    logic [W_MIN-1:0]  MIN;
    logic [W_HOUR-1:0] HOUR;
    logic [W_MIN-1:0]  AMIN;
    logic [W_HOUR-1:0] AHOUR;
    logic              ALARM;
    logic              ALARM_EN;
    logic              RING;
    logic [2:0]        STATE;

    modport master (
        output BTN_MODE, BTN_INC,
        input  SEC, MIN, HOUR, AMIN, AHOUR, ALARM, ALARM_EN, RING, STATE
    );

    modport slave (
        input  BTN_MODE, BTN_INC,
        output SEC, MIN, HOUR, AMIN, AHOUR, ALARM, ALARM_EN, RING, STATE
    );

endinterface

// File: rtl/reloj_base_tiempo_contador_mod.sv
// Modulo-N counter with synchronous clear and a combinational carry-out.
// Latency: value updates on the edge where inc/clr is sampled; carry is same-cycle.
// Backpressure: none; clr has priority over inc.
module contador_mod #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] TOP = W'(N - 1);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // next count: clear wins, otherwise step and wrap at N-1
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = (value_q == TOP) ? '0 : value_q + W'(1);
        end
    end

    // count register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == TOP);

endmodule

// File: rtl/reloj_base_tiempo.sv
// Clock core: 1 Hz prescaler, time/alarm counters, set-mode FSM, alarm ringer.
// Latency: every output is registered; a press or tick shows one edge later.
// Backpressure: none; button presses are edge-detected levels, one action each.
module reloj_base_tiempo #(
    parameter int CLK_HZ    = 50000000,
    parameter int RING_SECS = 60
) (
    input logic CLK,
    input logic RST_N,
    reloj_base_tiempo_if.slave bus
);
    import reloj_pkg::*;

    localparam int                W_PRE     = $clog2(CLK_HZ);
    localparam logic [W_PRE-1:0]  PRE_TOP   = W_PRE'(CLK_HZ - 1);
    localparam logic [W_RING-1:0] RING_LOAD = W_RING'(RING_SECS);

    logic [W_PRE-1:0]  pre_q, pre_d;
    state_e            state_q, state_d;
    logic              alarm_en_q, alarm_en_d;
    logic              ring_q, ring_d;
    logic [W_RING-1:0] ring_cnt_q, ring_cnt_d;
    logic              alarm_q, alarm_d;
    logic              mode_prev_q, inc_prev_q;
    // blocks presses on the first edge after reset so a held button is ignored
    logic              armed_q;

    logic              tick, mode_press, inc_press, silence, mode_act, inc_act;
    logic              leave_set_min, time_run, alarm_hit, match_min, match_hour;
    logic              sec_inc, min_inc, hour_inc, amin_inc, ahour_inc;
    logic              sec_carry, min_carry, hour_carry;
    logic              unused_amin_carry, unused_ahour_carry;
    logic [W_SEC-1:0]  sec_val;
    logic [W_MIN-1:0]  min_val, amin_val;
    logic [W_HOUR-1:0] hour_val, ahour_val;

    // press decode and counter enables; a press while ringing only silences
    always_comb begin
        tick          = (pre_q == PRE_TOP);
        mode_press    = armed_q && bus.BTN_MODE && !mode_prev_q;
        inc_press     = armed_q && bus.BTN_INC && !inc_prev_q;
        silence       = ring_q && (mode_press || inc_press);
        mode_act      = mode_press && !ring_q;
        inc_act       = inc_press && !mode_press && !ring_q;
        leave_set_min = mode_act && (state_q == SET_MIN);
        time_run      = (state_q == RUN) || (state_q == SET_AHOUR) || (state_q == SET_AMIN);
        sec_inc       = tick && time_run;
        min_inc       = sec_carry || (inc_act && (state_q == SET_MIN));
        hour_inc      = (min_carry && time_run) || (inc_act && (state_q == SET_HOUR));
        amin_inc      = inc_act && (state_q == SET_AMIN);
        ahour_inc     = inc_act && (state_q == SET_AHOUR);
    end

    contador_mod #(.N(MAX_SEC + 1), .W(W_SEC)) u_sec (
        .CLK(CLK), .RST_N(RST_N), .inc(sec_inc), .clr(leave_set_min),
        .value(sec_val), .carry(sec_carry));
    contador_mod #(.N(MAX_MIN + 1), .W(W_MIN)) u_min (
        .CLK(CLK), .RST_N(RST_N), .inc(min_inc), .clr(1'b0),
        .value(min_val), .carry(min_carry));
    contador_mod #(.N(MAX_HOUR + 1), .W(W_HOUR)) u_hour (
        .CLK(CLK), .RST_N(RST_N), .inc(hour_inc), .clr(1'b0),
        .value(hour_val), .carry(hour_carry));
    contador_mod #(.N(MAX_MIN + 1), .W(W_MIN)) u_amin (
        .CLK(CLK), .RST_N(RST_N), .inc(amin_inc), .clr(1'b0),
        .value(amin_val), .carry(unused_amin_carry));
    contador_mod #(.N(MAX_HOUR + 1), .W(W_HOUR)) u_ahour (
        .CLK(CLK), .RST_N(RST_N), .inc(ahour_inc), .clr(1'b0),
        .value(ahour_val), .carry(unused_ahour_carry));

    // alarm compares against the time this tick produces, i.e. HH:MM:00 after rollover
    always_comb begin
        match_min  = min_carry ? (amin_val == '0) : (amin_val == min_val + W_MIN'(1));
        if (hour_carry) begin
            match_hour = (ahour_val == '0);
        end else if (min_carry) begin
            match_hour = (ahour_val == hour_val + W_HOUR'(1));
        end else begin
            match_hour = (ahour_val == hour_val);
        end
        alarm_hit = (state_q == RUN) && alarm_en_q && sec_carry && match_min && match_hour;
    end

    // FSM, alarm enable, prescaler and ringer next-state
    always_comb begin
        state_d    = mode_act ? next_state(state_q) : state_q;
        alarm_en_d = alarm_en_q ^ (inc_act && (state_q == RUN));
        pre_d      = (tick || leave_set_min) ? '0 : pre_q + W_PRE'(1);
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (ring_q && tick) begin
            ring_cnt_d = ring_cnt_q - W_RING'(1);
            if (ring_cnt_q == W_RING'(1)) begin
                ring_d = 1'b0;
            end
        end
        if (alarm_hit) begin
            ring_d     = 1'b1;
            ring_cnt_d = RING_LOAD;
        end
        if (silence || (state_d != RUN) || !alarm_en_d) begin
            ring_d = 1'b0;
        end
        alarm_d = (state_d == SET_AHOUR) || (state_d == SET_AMIN);
    end

    // control registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre_q       <= '0;
            state_q     <= RUN;
            alarm_en_q  <= 1'b0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= '0;
            alarm_q     <= 1'b0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            state_q     <= state_d;
            alarm_en_q  <= alarm_en_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
            alarm_q     <= alarm_d;
            mode_prev_q <= bus.BTN_MODE;
            inc_prev_q  <= bus.BTN_INC;
            armed_q     <= 1'b1;
        end
    end

    assign bus.SEC      = sec_val;
    assign bus.MIN      = min_val;
    assign bus.HOUR     = hour_val;
    assign bus.AMIN     = amin_val;
    assign bus.AHOUR    = ahour_val;
    assign bus.ALARM    = alarm_q;
    assign bus.ALARM_EN = alarm_en_q;
    assign bus.RING     = ring_q;
    assign bus.STATE    = state_q;

endmodule

// File: tb/tb_reloj_base_tiempo.sv
// Bench for the clock core: directed scenarios plus random button traffic.
// Latency: expected outputs are queued one edge ahead of the DUT.
// Backpressure: none; a monitor pops one expectation per clock edge.
`timescale 1ns/1ps
module tb_reloj_base_tiempo;

    localparam int CLK_HZ    = 4;
    localparam int RING_SECS = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    reloj_base_tiempo_if bus();

    reloj_base_tiempo #(.CLK_HZ(CLK_HZ), .RING_SECS(RING_SECS)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];

    // reference model: time of day in seconds, set-mode index 0..4
    int m_tod, m_ah, m_am, m_st, m_pre, m_rleft;
    bit m_en, m_ring, m_armed, m_pm, m_pi;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [33:0] dut_vec();
        return {bus.SEC, bus.MIN, bus.HOUR, bus.AMIN, bus.AHOUR,
                bus.ALARM, bus.ALARM_EN, bus.RING, bus.STATE};
    endfunction

    function automatic logic [33:0] m_out();
        return {6'(m_tod % 60), 6'((m_tod / 60) % 60), 5'(m_tod / 3600), 6'(m_am), 5'(m_ah),
                1'(m_st == 3 || m_st == 4), 1'(m_en), 1'(m_ring), 3'(m_st)};
    endfunction

    task automatic m_reset();
        m_tod = 0; m_ah = 0; m_am = 0; m_st = 0; m_pre = 0; m_rleft = 0;
        m_en = 0; m_ring = 0; m_armed = 0; m_pm = 0; m_pi = 0;
    endtask

    task automatic m_step(input bit bm, input bit bi);
        bit pm, pi, tick, run, consumed, was_ring, old_en;
        int old_st, h, mi;
        pm = m_armed && bm && !m_pm;
        pi = m_armed && bi && !m_pi;
        m_pm = bm; m_pi = bi; m_armed = 1;
        tick  = (m_pre == CLK_HZ - 1);
        m_pre = tick ? 0 : m_pre + 1;
        old_st = m_st; old_en = m_en; was_ring = m_ring;
        run = (old_st == 0 || old_st == 3 || old_st == 4);
        consumed = was_ring && (pm || pi);
        if (tick && run) m_tod = (m_tod + 1) % 86400;
        if (!consumed && pm) begin
            if (old_st == 2) begin
                m_tod = m_tod - (m_tod % 60);
                m_pre = 0;
            end
            m_st = (old_st + 1) % 5;
        end else if (!consumed && pi) begin
            h  = m_tod / 3600;
            mi = (m_tod / 60) % 60;
            case (old_st)
                0: m_en = !m_en;
                1: m_tod = m_tod + (((h + 1) % 24) - h) * 3600;
                2: m_tod = m_tod + (((mi + 1) % 60) - mi) * 60;
                3: m_ah = (m_ah + 1) % 24;
                default: m_am = (m_am + 1) % 60;
            endcase
        end
        if (was_ring && tick) begin
            m_rleft--;
            if (m_rleft == 0) m_ring = 0;
        end
        if (old_st == 0 && old_en && tick && m_tod == m_ah * 3600 + m_am * 60) begin
            m_ring = 1;
            m_rleft = RING_SECS;
        end
        if (consumed || m_st != 0 || !m_en) m_ring = 0;
    endtask

    task automatic cycle(input bit bm, input bit bi);
        @(negedge CLK);
        bus.BTN_MODE = bm;
        bus.BTN_INC  = bi;
        m_step(bm, bi);
        exp_q.push_back(m_out());
    endtask

    task automatic press(input bit bm, input bit bi);
        cycle(bm, bi);
        cycle(1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sec"}, bus.SEC, 0);
        check({tag, "_min"}, bus.MIN, 0);
        check({tag, "_hour"}, bus.HOUR, 0);
        check({tag, "_amin"}, bus.AMIN, 0);
        check({tag, "_ahour"}, bus.AHOUR, 0);
        check({tag, "_alarm"}, bus.ALARM, 0);
        check({tag, "_alarm_en"}, bus.ALARM_EN, 0);
        check({tag, "_ring"}, bus.RING, 0);
        check({tag, "_state"}, bus.STATE, 0);
    endtask

    // reset lands between edges; outputs must clear before any clock edge
    task automatic assert_reset(input string tag);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check_zero(tag);
        repeat (2) @(negedge CLK);
    endtask

    task automatic release_rst(input bit bm, input bit bi);
        @(negedge CLK);
        bus.BTN_MODE = bm;
        bus.BTN_INC  = bi;
        RST_N = 1'b1;
        m_reset();
        m_step(bm, bi);
        exp_q.push_back(m_out());
    endtask

    task automatic setup_alarm();
        assert_reset("rst_pre_alarm");
        release_rst(1'b0, 1'b0);
        press(1'b1, 1'b0);          // SET_HOUR
        press(1'b1, 1'b0);          // SET_MIN
        press(1'b0, 1'b1);          // 00:01
        press(1'b1, 1'b0);          // SET_AHOUR, seconds cleared
        press(1'b1, 1'b0);          // SET_AMIN
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);          // alarm 00:02
        press(1'b1, 1'b0);          // RUN
        press(1'b0, 1'b1);          // arm
    endtask

    task automatic wait_ring();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cycle(1'b0, 1'b0);
            settle();
            seen = bus.RING;
        end
        check("ring_rises", seen, 1);
    endtask

    // monitor: every edge out of reset is compared against the queued expectation
    initial begin : monitor
        logic [33:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (RST_N && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (dut_vec() !== e) begin
                    bad++;
                    $display("FAIL outputs @%0t: got %h expected %h", $time, dut_vec(), e);
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bit seen;
        bus.BTN_MODE = 1'b0;
        bus.BTN_INC  = 1'b0;
        m_reset();
        repeat (2) @(negedge CLK);
        check_zero("in_reset");

        // free-running count from reset
        release_rst(1'b0, 1'b0);
        settle();
        check_zero("after_reset");
        repeat (238) cycle(1'b0, 1'b0);
        settle();
        check("free_sec59", bus.SEC, 59);
        check("free_min0", bus.MIN, 0);
        cycle(1'b0, 1'b0);
        settle();
        check("free_sec0", bus.SEC, 0);
        check("free_min1", bus.MIN, 1);

        // set time to 23:59 and watch midnight
        assert_reset("rst_set_time");
        release_rst(1'b0, 1'b0);
        press(1'b1, 1'b0);
        repeat (23) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        settle();
        check("set_hour23", bus.HOUR, 23);
        check("set_min59", bus.MIN, 59);
        check("set_sec0", bus.SEC, 0);
        check("set_state_ahour", bus.STATE, 3);
        check("set_alarm_view", bus.ALARM, 1);
        cycle(1'b0, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cycle(1'b0, 1'b0);
            settle();
            seen = (bus.HOUR == 0 && bus.MIN == 0 && bus.SEC == 0);
        end
        check("midnight_rollover", seen, 1);

        // alarm match and ring duration
        setup_alarm();
        wait_ring();
        check("ring_hour", bus.HOUR, 0);
        check("ring_min", bus.MIN, 2);
        check("ring_sec", bus.SEC, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0);
            settle();
            n++;
            if (!bus.RING) break;
        end
        check("ring_length", n, RING_SECS * CLK_HZ);

        // silencing press is consumed
        setup_alarm();
        wait_ring();
        cycle(1'b0, 1'b1);
        settle();
        check("silence_ring", bus.RING, 0);
        check("silence_en", bus.ALARM_EN, 1);
        check("silence_state", bus.STATE, 0);
        cycle(1'b0, 1'b0);
        assert_reset("rst_mid_ring_after_silence");

        // MODE beats INC on the same edge
        release_rst(1'b0, 1'b0);
        press(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        settle();
        check("simul_state", bus.STATE, 2);
        check("simul_hour", bus.HOUR, 0);
        cycle(1'b0, 1'b0);

        // buttons held across reset release do nothing
        assert_reset("rst_held");
        release_rst(1'b1, 1'b1);
        repeat (4) cycle(1'b1, 1'b1);
        settle();
        check("held_state", bus.STATE, 0);
        check("held_en", bus.ALARM_EN, 0);
        cycle(1'b0, 1'b0);

        // async reset from SET_AMIN, then from mid-ring
        repeat (4) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        assert_reset("rst_set_amin");
        setup_alarm();
        wait_ring();
        assert_reset("rst_ringing");

        // random button traffic against the model
        release_rst(1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
        end
        settle();
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
